pq_scheduler: RTL and testbench

Round-robin scheduler that shares one `pqueue` min-heap among R requesters. Each requester issues PUSH or POP requests over a valid/ready handshake. The scheduler serialises them onto the queue's single `cmd`/`in` port, gates illegal operations using the queue's `full`/`empty` flags, and returns popped values to the requester that asked. It sits between client logic and one `pqueue` instance and is the only driver of that instance's `cmd` and `in`.

---
 rtl/pq_scheduler.sv | 112 +++++++++++
 tb/tb_pq_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pq_scheduler.sv
// Round-robin front end that serialises PUSH/POP requests from R clients onto one
// pqueue min-heap, gating on the heap's full/empty flags and routing pop results back.
module pq_scheduler #(
  parameter int R   = 4,
  parameter int MSB = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [R-1:0]       req_valid,
  input  logic [R-1:0]       req_pop,
  input  logic [R*(MSB+1)-1:0] req_data,
  output logic [R-1:0]       req_ready,
  output logic [R-1:0]       rsp_valid,
  output logic [MSB:0]       rsp_data,
  output logic [1:0]         pq_cmd,
  output logic [MSB:0]       pq_in,
  input  logic [MSB:0]       pq_out,
  input  logic               pq_full,
  input  logic               pq_empty,
  output logic               busy
);

  localparam int W  = MSB + 1;
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  localparam logic [1:0] CMD_NOOP = 2'd0;
  localparam logic [1:0] CMD_PUSH = 2'd1;
  localparam logic [1:0] CMD_POP  = 2'd2;

  typedef enum logic {IDLE, POP_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   pend_id_q, pend_id_d;
  logic [R-1:0]    rsp_valid_q, rsp_valid_d;
  logic [MSB:0]    rsp_data_q, rsp_data_d;

  logic [R-1:0]    elig;
  logic            found;
  logic            grant;
  logic [PW-1:0]   gnt;
  logic [R-1:0]    gnt_onehot;
  logic [R-1:0]    pend_onehot;

  always_comb begin
    elig        = req_valid & ~(req_pop & {R{pq_empty}}) & ~(~req_pop & {R{pq_full}});
    found       = 1'b0;
    gnt         = '0;
    // First eligible requester at or after rr_ptr, wrapping; ineligible ones are skipped.
    for (int k = 0; k < R; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % R;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
    grant       = found && (state_q == IDLE) && !reset;
    gnt_onehot  = '0;
    gnt_onehot[gnt] = 1'b1;
    pend_onehot = '0;
    pend_onehot[pend_id_q] = 1'b1;

    req_ready   = '0;
    pq_cmd      = CMD_NOOP;
    pq_in       = '0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    pend_id_d   = pend_id_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (state_q == POP_WAIT) begin
      // Heap has settled one cycle after the POP; capture its new output for the client.
      rsp_valid_d = pend_onehot;
      rsp_data_d  = pq_out;
      state_d     = IDLE;
    end else if (grant) begin
      req_ready = gnt_onehot;
      rr_ptr_d  = (gnt == PW'(R - 1)) ? '0 : gnt + PW'(1);
      if (req_pop[gnt]) begin
        pq_cmd    = CMD_POP;
        pend_id_d = gnt;
        state_d   = POP_WAIT;
      end else begin
        pq_cmd = CMD_PUSH;
        pq_in  = req_data[int'(gnt)*W +: W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      pend_id_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_id_q   <= pend_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q == POP_WAIT);

endmodule

// File: tb/tb_pq_scheduler.sv
// Directed bench for pq_scheduler; the heap's out/full/empty are driven by hand
// to the values a pqueue would present at each step.
module tb_pq_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_pop;
  logic [11:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [2:0]  rsp_data;
  logic [1:0]  pq_cmd;
  logic [2:0]  pq_in;
  logic [2:0]  pq_out;
  logic        pq_full;
  logic        pq_empty;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  pq_scheduler #(.R(4), .MSB(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_pop(req_pop), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pq_cmd(pq_cmd), .pq_in(pq_in), .pq_out(pq_out),
    .pq_full(pq_full), .pq_empty(pq_empty), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1 later.
  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b0000;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'b1111;
    req_pop = 4'b0000;
    req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    pq_out = 3'd0;
    pq_full = 1'b0;
    pq_empty = 1'b1;

    // Reset held two cycles with all requesters valid
    next_cycle();
    next_cycle();
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_cmd", pq_cmd, 2'd0);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_data", rsp_data, 3'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_first_grant", req_ready, 4'b0001);

    // Single push
    do_reset();
    req_valid = 4'b0001; req_pop = 4'b0000; req_data = {3'd0, 3'd0, 3'd0, 3'd5};
    #1;
    check("push_ready", req_ready, 4'b0001);
    check("push_cmd", pq_cmd, 2'd1);
    check("push_in", pq_in, 3'd5);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("push_after_cmd", pq_cmd, 2'd0);
    check("push_after_ready", req_ready, 4'b0000);

    // Round robin over four pushers
    do_reset();
    req_valid = 4'b1111; req_pop = 4'b0000; req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    check("rr_g0", req_ready, 4'b0001);
    check("rr_in0", pq_in, 3'd1);
    next_cycle(); req_valid = 4'b1110; #1;
    check("rr_g1", req_ready, 4'b0010);
    check("rr_in1", pq_in, 3'd2);
    next_cycle(); req_valid = 4'b1100; #1;
    check("rr_g2", req_ready, 4'b0100);
    check("rr_in2", pq_in, 3'd3);
    next_cycle(); req_valid = 4'b1000; #1;
    check("rr_g3", req_ready, 4'b1000);
    check("rr_in3", pq_in, 3'd4);
    next_cycle(); req_valid = 4'b1111; #1;
    check("rr_wrap", req_ready, 4'b0001);
    next_cycle(); req_valid = 4'b0000;

    // Pop response: push 3, push 1, requester 2 pops
    do_reset();
    pq_empty = 1'b1;
    req_valid = 4'b0001; req_pop = 4'b0000; req_data = {3'd0, 3'd0, 3'd1, 3'd3};
    #1;
    check("pop_push3_in", pq_in, 3'd3);
    next_cycle();
    pq_empty = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("pop_push1_ready", req_ready, 4'b0010);
    check("pop_push1_in", pq_in, 3'd1);
    next_cycle();
    req_valid = 4'b0100; req_pop = 4'b0100;
    #1;
    check("pop_t_ready", req_ready, 4'b0100);
    check("pop_t_cmd", pq_cmd, 2'd2);
    check("pop_t_in", pq_in, 3'd0);
    next_cycle();
    req_valid = 4'b0001; req_pop = 4'b0000; pq_out = 3'd1;
    #1;
    check("pop_t1_busy", busy, 1'b1);
    check("pop_t1_cmd", pq_cmd, 2'd0);
    check("pop_t1_ready", req_ready, 4'b0000);
    check("pop_t1_rsp_valid", rsp_valid, 4'b0000);
    next_cycle();
    pq_out = 3'd3;
    #1;
    check("pop_t2_rsp_valid", rsp_valid, 4'b0100);
    check("pop_t2_rsp_data", rsp_data, 3'd1);
    check("pop_t2_busy", busy, 1'b0);
    check("pop_t2_grant", req_ready, 4'b0001);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("pop_t3_pulse", rsp_valid, 4'b0000);
    check("pop_t3_hold", rsp_data, 3'd1);

    // Flag gating: full heap blocks pushes, empty heap blocks pops
    do_reset();
    pq_full = 1'b1; pq_empty = 1'b0;
    req_valid = 4'b0011; req_pop = 4'b0010;
    #1;
    check("full_ready", req_ready, 4'b0010);
    check("full_cmd", pq_cmd, 2'd2);
    next_cycle();
    req_valid = 4'b0001; req_pop = 4'b0000;
    #1;
    check("full_wait_ready", req_ready, 4'b0000);
    next_cycle();
    #1;
    check("full_push_blocked", req_ready, 4'b0000);
    check("full_push_cmd", pq_cmd, 2'd0);
    pq_full = 1'b0; pq_empty = 1'b1;
    req_valid = 4'b1111; req_pop = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      check("empty_ready", req_ready, 4'b0000);
      check("empty_cmd", pq_cmd, 2'd0);
    end

    // Reset during POP_WAIT
    do_reset();
    pq_full = 1'b0; pq_empty = 1'b0;
    req_valid = 4'b0100; req_pop = 4'b0100;
    #1;
    check("rstpop_grant", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b0000; reset = 1'b1; pq_out = 3'd6;
    #1;
    check("rstpop_busy_wait", busy, 1'b1);
    check("rstpop_ready_in_rst", req_ready, 4'b0000);
    next_cycle();
    reset = 1'b0;
    req_valid = 4'b1111; req_pop = 4'b0000;
    #1;
    check("rstpop_busy", busy, 1'b0);
    check("rstpop_rsp_valid", rsp_valid, 4'b0000);
    check("rstpop_rr", req_ready, 4'b0001);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("rstpop_rsp_valid2", rsp_valid, 4'b0000);
    check("rstpop_rsp_data", rsp_data, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
